// File: rtl/uart_string_tx.sv
// UART transmitter that sends a latched string of CHAR_NR bytes, MSB byte first,
// with a one-entry pending buffer so back-to-back strings leave no gap on the line.
module uart_string_tx #(
  parameter int CHAR_NR     = 8,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHAR_NR*8-1:0] char_array_i,
  input  logic                 char_array_update_i,
  input  logic                 clr_i,
  output logic                 busy_o,
  output logic                 txd_o,
  output logic                 done_o,
  output logic                 overrun_o
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (CHAR_NR > 1) ? $clog2(CHAR_NR) : 1;
  localparam int STR_W = CHAR_NR * 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   baud_cnt;
  logic [2:0]         bit_cnt;
  logic               stop_cnt;
  logic [IDX_W-1:0]   char_idx;
  logic [STR_W-1:0]   active_str;
  logic [STR_W-1:0]   pend_str;
  logic               pend_full;
  logic               abort;
  logic [7:0]         cur_char;
  logic               bit_end;
  logic               last_stop;
  logic               last_char;
  logic               abort_now;
  logic               upd;

  function automatic logic parity_bit(input logic [7:0] d);
    return (PARITY == 2) ? ~(^d) : (^d);
  endfunction

  // The active string is shifted left per character, so the current one is always the top byte.
  assign cur_char  = active_str[STR_W-1 -: 8];
  assign bit_end   = (baud_cnt == CNT_W'(DIV - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign last_char = (char_idx == IDX_W'(CHAR_NR - 1));
  assign abort_now = abort | clr_i;
  assign upd       = char_array_update_i & ~clr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      txd_o     <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      char_idx  <= '0;
      pend_full <= 1'b0;
      abort     <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
      if (state == IDLE) begin
        txd_o  <= 1'b1;
        busy_o <= 1'b0;
        abort  <= 1'b0;
        if (clr_i) begin
          pend_full <= 1'b0;
        end else if (char_array_update_i) begin
          active_str <= char_array_i;
          state      <= START;
          txd_o      <= 1'b0;
          busy_o     <= 1'b1;
          baud_cnt   <= '0;
          char_idx   <= '0;
        end
      end else begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
        if (clr_i) begin
          abort     <= 1'b1;
          pend_full <= 1'b0;
        end else if (char_array_update_i) begin
          pend_str  <= char_array_i;
          pend_full <= 1'b1;
          overrun_o <= pend_full;
        end
        if (bit_end) begin
          case (state)
            START: begin
              state   <= DATA;
              txd_o   <= cur_char[0];
              bit_cnt <= '0;
            end
            DATA: begin
              if (bit_cnt == 3'd7) begin
                if (PARITY != 0) begin
                  state <= PARITY_BIT;
                  txd_o <= parity_bit(cur_char);
                end else begin
                  state    <= STOP;
                  txd_o    <= 1'b1;
                  stop_cnt <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                txd_o   <= cur_char[bit_cnt + 3'd1];
              end
            end
            PARITY_BIT: begin
              state    <= STOP;
              txd_o    <= 1'b1;
              stop_cnt <= 1'b0;
            end
            STOP: begin
              if (!last_stop) begin
                stop_cnt <= stop_cnt + 1'b1;
              end else if (abort_now) begin
                state  <= IDLE;
                txd_o  <= 1'b1;
                busy_o <= 1'b0;
                abort  <= 1'b0;
              end else if (!last_char) begin
                char_idx   <= char_idx + 1'b1;
                active_str <= active_str << 8;
                state      <= START;
                txd_o      <= 1'b0;
              end else begin
                // String complete: chain straight into whatever is waiting, pending first.
                done_o   <= 1'b1;
                char_idx <= '0;
                if (pend_full) begin
                  active_str <= pend_str;
                  pend_full  <= upd;
                  overrun_o  <= 1'b0;
                  state      <= START;
                  txd_o      <= 1'b0;
                end else if (upd) begin
                  active_str <= char_array_i;
                  pend_full  <= 1'b0;
                  state      <= START;
                  txd_o      <= 1'b0;
                end else begin
                  state  <= IDLE;
                  txd_o  <= 1'b1;
                  busy_o <= 1'b0;
                end
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
